fetch_queue: RTL

- Consumer end of the program-counter interface.
- Each cycle, takes the current PC (pc_in), drives the synchronous instruction memory, and buffers returned {pc, instr} pairs in a small FIFO toward decode.
- Closes the loop back to the PC through pc_bra/select:
  - redirects on a predecoded unconditional jump;
  - replays the PC when decode back-pressure overflows the FIFO.
- The PC free-runs with no stall input, so this block owns all flow control.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side bundle: PC in, instruction memory port, redirect strobe and decode queue head.
interface fetch_queue_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] pc_in;
    logic [AW-1:0] imem_addr;
    logic          imem_en;
    logic [31:0]   imem_rdata;
    logic [AW-1:0] pc_bra;
    logic          select;
    logic [31:0]   dec_instr;
    logic [AW-1:0] dec_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic [CW-1:0] fifo_count;

    modport master (
        input  pc_in, imem_rdata, dec_ready,
        output imem_addr, imem_en, pc_bra, select,
               dec_instr, dec_pc, dec_valid, fifo_count
    );

    modport slave (
        output pc_in, imem_rdata, dec_ready,
        input  imem_addr, imem_en, pc_bra, select,
               dec_instr, dec_pc, dec_valid, fifo_count
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch queue with overflow replay; jump predecode redirect when FETCH_PREDECODE_EN is defined.
module fetch_queue #(
    parameter int DEPTH = 4,
`ifdef FETCH_PREDECODE_EN
    parameter logic [5:0] JMP_OPCODE = 6'b000010,
`endif
    parameter int AW = 32
) (
    input  logic           clk,
    input  logic           reset,
    fetch_queue_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [AW-1:0] req_pc;
    logic          rsp_valid;

    logic [31:0]   mem_instr [DEPTH];
    logic [AW-1:0] mem_pc    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] bra_hold;

    logic          cand;
    logic          full;
    logic          pop;
    logic          push;
    logic          overflow;
    logic          jump;
    logic          redirect;
    logic [AW-1:0] bra_target;

    assign bus.imem_addr = bus.pc_in;
    assign bus.imem_en   = ~reset;

    // Response stage: imem_rdata this cycle belongs to the PC issued last cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            req_pc    <= bus.pc_in;
            rsp_valid <= bus.imem_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (redirect) state_next = SQUASH;
            SQUASH:  state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        cand       = rsp_valid && (state == RUN) && !reset;
        full       = (count == CW'(DEPTH));
        pop        = (count != '0) && bus.dec_ready;
        overflow   = cand && full && !pop;
        push       = cand && !overflow;
        jump       = 1'b0;
        bra_target = req_pc;
`ifdef FETCH_PREDECODE_EN
        jump = push && (bus.imem_rdata[31:26] == JMP_OPCODE);
        // Replay wins: on overflow the target is the dropped word's own PC.
        if (!overflow) begin
            bra_target = req_pc + {{(AW-16){bus.imem_rdata[15]}}, bus.imem_rdata[15:0]};
        end
`endif
        redirect   = overflow || jump;
        bus.select = redirect;
        bus.pc_bra = redirect ? bra_target : bra_hold;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]    <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            bra_hold <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (redirect) bra_hold <= bra_target;
        end
    end

    assign bus.dec_valid  = (count != '0);
    assign bus.dec_instr  = bus.dec_valid ? mem_instr[rd_ptr] : '0;
    assign bus.dec_pc     = bus.dec_valid ? mem_pc[rd_ptr] : '0;
    assign bus.fifo_count = count;
endmodule
